mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning max cycles in BUSY before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports exactly as listed:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- validE  in  1  execute-stage instruction present.
- regWriteE  in  1  instruction writes register file.
- memToRegE  in  1  load.
- memWriteE  in  1  store.
- PCSrcE  in  1  PC-source flag, passed through.
- WA3E  in  4  destination register.
- aluResE  in  24  ALU result; [15:0] is memory address.
- dataE  in  24  store data.
- stallE  out  1  upstream must hold its current outputs.
- memReq  out  1  data-memory request.
- memWe  out  1  request is a write.
- memAddr  out  16  memory address.
- memWdata  out  24  store data.
- memRdata  in  24  load data, valid with memAck.
- memAck  in  1  access complete.
- result  out  24  writeback value.
- regWriteW  out  1  writeback enable.
- WA3W  out  4  writeback register.
- PCSrcW  out  1  PC-source flag, writeback stage.
- validW  out  1  one-cycle pulse per retired instruction.
- memErr  out  1  timeout pulse.

Function
REQ-003 FSM states SHALL be IDLE and BUSY; all outputs registered except stallE = (state==BUSY).
REQ-004 Store SHALL be memWriteE=1; load SHALL be memToRegE=1 and memWriteE=0; anything else is ALU-only.
REQ-005 In IDLE with validE=1, ALU-only op SHALL retire next cycle: validW=1, result=aluResE, regWriteW=regWriteE, WA3W=WA3E, PCSrcW=PCSrcE (latency 1).
REQ-006 In IDLE with validE=1, load/store SHALL latch address, data, WA3E, regWriteE, PCSrcE, kind; enter BUSY; drive memReq=1, memWe=store, memAddr, memWdata next cycle.
REQ-007 In BUSY, memReq/memWe/memAddr/memWdata SHALL stay constant and inputs on the E side SHALL be ignored.
REQ-008 In BUSY with memAck=1, next cycle SHALL be IDLE, memReq=0, validW=1; load: result=memRdata, regWriteW=latched regWriteE; store: result=latched address zero-extended, regWriteW=0.
REQ-009 memAck in IDLE SHALL be ignored; memAck arriving in the same cycle as entering BUSY does not exist (memReq not yet asserted).
REQ-010 validW SHALL be 0 in every cycle not defined above; regWriteW SHALL be 0 whenever validW=0.
REQ-011 memErr SHALL be 0 except as in REQ-015.

Reset
REQ-012 rst=1 at a clock edge SHALL force IDLE and all registered outputs to 0 (result=24'h0, WA3W=4'h0), including mid-BUSY; an in-flight access SHALL be abandoned without retirement.
REQ-013 The first cycle after rst deasserts SHALL accept a new instruction.

Configuration
REQ-014 Macro MEM_TIMEOUT_EN SHALL compile in a BUSY-cycle counter (reset to 0 on BUSY entry).
REQ-015 With MEM_TIMEOUT_EN: if counter reaches TIMEOUT_CYCLES with no memAck, next cycle IDLE, memReq=0, validW=1, regWriteW=0, memErr=1 for one cycle; memAck in that final cycle wins over timeout.
REQ-016 Without MEM_TIMEOUT_EN: no counter, memErr tied 0, BUSY waits indefinitely.

Structure
REQ-017 Package mem_wb_pkg SHALL hold DATA_W=24, ADDR_W=16, REG_W=4 and the state enum.
REQ-018 The MEM/WB output register SHALL be sub-module wb_register (result, regWriteW, WA3W, PCSrcW, validW).

Verification
REQ-019 ALU op aluResE=24'h00_1234, WA3E=3, regWriteE=1 -> next cycle validW=1, result=24'h001234, WA3W=3, regWriteW=1.
REQ-020 Load addr 16'h0040, memAck after 3 cycles with memRdata=24'hABCDEF -> stallE=1 for 4 cycles, then result=24'hABCDEF, regWriteW=1.
REQ-021 Store addr 16'h0010, dataE=24'h000055, memAck after 1 cycle -> memWe=1, memWdata=24'h000055, retire with regWriteW=0.
REQ-022 rst asserted in 2nd BUSY cycle -> next cycle memReq=0, validW=0, stallE=0, all outputs 0.
REQ-023 With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no memAck -> after 4 BUSY cycles memErr=1 one cycle, validW=1, regWriteW=0; without macro memReq stays 1.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// Shared widths, FSM state and operation-kind types for the MEM/WB stage.
// Consumers: mem_wb_stage, wb_register.
package mem_wb_pkg;

    localparam int unsigned DATA_W = 24;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic {
        StIdle,
        StBusy
    } state_e;

    typedef enum logic [1:0] {
        OpAlu,
        OpLoad,
        OpStore
    } op_e;

    // A store wins over the load flag when both are set.
    function automatic op_e decode_op(input logic mem_to_reg, input logic mem_write);
        op_e op;
        if (mem_write) begin
            op = OpStore;
        end else if (mem_to_reg) begin
            op = OpLoad;
        end else begin
            op = OpAlu;
        end
        return op;
    endfunction

endpackage

// File: rtl/wb_register.sv
// MEM/WB pipeline register: captures one retiring instruction per pulse of retire_i.
// validW and regWriteW are single-cycle; the other fields hold between retirements.
module wb_register
    import mem_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic              reg_write_i,
    input  logic [REG_W-1:0]  wa3_i,
    input  logic              pc_src_i,
    output logic [DATA_W-1:0] result_o,
    output logic              reg_write_o,
    output logic [REG_W-1:0]  wa3_o,
    output logic              pc_src_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] result_q, result_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_W-1:0]  wa3_q, wa3_d;
    logic              pc_src_q, pc_src_d;
    logic              valid_q, valid_d;

    always_comb begin
        result_d    = result_q;
        wa3_d       = wa3_q;
        pc_src_d    = pc_src_q;
        valid_d     = retire_i;
        reg_write_d = retire_i & reg_write_i;
        if (retire_i) begin
            result_d = result_i;
            wa3_d    = wa3_i;
            pc_src_d = pc_src_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q    <= '0;
            reg_write_q <= 1'b0;
            wa3_q       <= '0;
            pc_src_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            result_q    <= result_d;
            reg_write_q <= reg_write_d;
            wa3_q       <= wa3_d;
            pc_src_q    <= pc_src_d;
            valid_q     <= valid_d;
        end
    end

    assign result_o    = result_q;
    assign reg_write_o = reg_write_q;
    assign wa3_o       = wa3_q;
    assign pc_src_o    = pc_src_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: ALU ops retire in one cycle, loads/stores hold the pipe until memAck.
// Optional BUSY timeout with memErr pulse when MEM_TIMEOUT_EN is defined.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validE,
    input  logic              regWriteE,
    input  logic              memToRegE,
    input  logic              memWriteE,
    input  logic              PCSrcE,
    input  logic [REG_W-1:0]  WA3E,
    input  logic [DATA_W-1:0] aluResE,
    input  logic [DATA_W-1:0] dataE,
    output logic              stallE,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    input  logic              memAck,
    output logic [DATA_W-1:0] result,
    output logic              regWriteW,
    output logic [REG_W-1:0]  WA3W,
    output logic              PCSrcW,
    output logic              validW,
    output logic              memErr
);

    state_e state_q, state_d;
    op_e    op;
    logic   timeout;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              is_store_q, is_store_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_W-1:0]  wa3_q, wa3_d;
    logic              pc_src_q, pc_src_d;

    logic              retire;
    logic [DATA_W-1:0] ret_result;
    logic              ret_reg_write;
    logic [REG_W-1:0]  ret_wa3;
    logic              ret_pc_src;

    assign op = decode_op(memToRegE, memWriteE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (validE && op != OpAlu) state_d = StBusy;
            StBusy: if (memAck || timeout) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        is_store_d    = is_store_q;
        reg_write_d   = reg_write_q;
        wa3_d         = wa3_q;
        pc_src_d      = pc_src_q;
        retire        = 1'b0;
        ret_result    = '0;
        ret_reg_write = 1'b0;
        ret_wa3       = wa3_q;
        ret_pc_src    = pc_src_q;
        unique case (state_q)
            StIdle: begin
                if (validE && op == OpAlu) begin
                    retire        = 1'b1;
                    ret_result    = aluResE;
                    ret_reg_write = regWriteE;
                    ret_wa3       = WA3E;
                    ret_pc_src    = PCSrcE;
                end else if (validE) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (op == OpStore);
                    mem_addr_d  = aluResE[ADDR_W-1:0];
                    mem_wdata_d = dataE;
                    is_store_d  = (op == OpStore);
                    reg_write_d = regWriteE;
                    wa3_d       = WA3E;
                    pc_src_d    = PCSrcE;
                end
            end
            StBusy: begin
                // An ack in the last allowed cycle takes priority over the timeout.
                if (memAck) begin
                    mem_req_d     = 1'b0;
                    mem_we_d      = 1'b0;
                    retire        = 1'b1;
                    ret_result    = is_store_q ? {{(DATA_W - ADDR_W){1'b0}}, mem_addr_q}
                                               : memRdata;
                    ret_reg_write = !is_store_q && reg_write_q;
                end else if (timeout) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    retire    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            is_store_q  <= 1'b0;
            reg_write_q <= 1'b0;
            wa3_q       <= '0;
            pc_src_q    <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            is_store_q  <= is_store_d;
            reg_write_q <= reg_write_d;
            wa3_q       <= wa3_d;
            pc_src_q    <= pc_src_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] busy_cnt_q, busy_cnt_d;
    logic            mem_err_q, mem_err_d;

    // Counter holds the number of BUSY cycles already completed without an ack.
    always_comb begin
        busy_cnt_d = busy_cnt_q;
        if (state_q == StIdle) begin
            busy_cnt_d = '0;
        end else if (!memAck) begin
            busy_cnt_d = busy_cnt_q + CntW'(1);
        end
        mem_err_d = timeout;
    end

    assign timeout = (state_q == StBusy) && !memAck &&
                     (busy_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            busy_cnt_q <= busy_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign memErr = mem_err_q;
`else
    logic unused_timeout_cycles;

    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout               = 1'b0;
    assign memErr                = 1'b0;
`endif

    wb_register u_wb_register (
        .clk         (clk),
        .rst         (rst),
        .retire_i    (retire),
        .result_i    (ret_result),
        .reg_write_i (ret_reg_write),
        .wa3_i       (ret_wa3),
        .pc_src_i    (ret_pc_src),
        .result_o    (result),
        .reg_write_o (regWriteW),
        .wa3_o       (WA3W),
        .pc_src_o    (PCSrcW),
        .valid_o     (validW)
    );

    assign stallE   = (state_q == StBusy);
    assign memReq   = mem_req_q;
    assign memWe    = mem_we_q;
    assign memAddr  = mem_addr_q;
    assign memWdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized scoreboard bench for mem_wb_stage with a memory responder model.
// Expectations also cover the MEM_TIMEOUT_EN build (timeout of 4 cycles there).
module tb_mem_wb_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned TO    = 4;
    localparam bit          TO_EN = 1'b1;
`else
    localparam int unsigned TO    = 15;
    localparam bit          TO_EN = 1'b0;
`endif

    typedef struct {
        logic [23:0] result;
        bit          chk_result;
        logic        reg_write;
        logic [3:0]  wa3;
        logic        pc_src;
        logic        err;
        bit          is_mem;
        int unsigned issue;
        int unsigned ret;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [23:0] wdata;
    } req_t;

    logic        clk;
    logic        rst;
    logic        validE, regWriteE, memToRegE, memWriteE, PCSrcE;
    logic [3:0]  WA3E;
    logic [23:0] aluResE, dataE;
    logic        stallE, memReq, memWe;
    logic [15:0] memAddr;
    logic [23:0] memWdata, memRdata;
    logic        memAck;
    logic [23:0] result;
    logic        regWriteW, PCSrcW, validW, memErr;
    logic [3:0]  WA3W;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int unsigned delay_q[$];
    logic [23:0] ref_mem[logic [15:0]];
    logic [23:0] phys_mem[logic [15:0]];

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_wb_stage #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .validE    (validE),
        .regWriteE (regWriteE),
        .memToRegE (memToRegE),
        .memWriteE (memWriteE),
        .PCSrcE    (PCSrcE),
        .WA3E      (WA3E),
        .aluResE   (aluResE),
        .dataE     (dataE),
        .stallE    (stallE),
        .memReq    (memReq),
        .memWe     (memWe),
        .memAddr   (memAddr),
        .memWdata  (memWdata),
        .memRdata  (memRdata),
        .memAck    (memAck),
        .result    (result),
        .regWriteW (regWriteW),
        .WA3W      (WA3W),
        .PCSrcW    (PCSrcW),
        .validW    (validW),
        .memErr    (memErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] dflt(input logic [15:0] a);
        return {a[7:0], a ^ 16'hA5C3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stallE"}, stallE, 0);
        check({tag, "_memReq"}, memReq, 0);
        check({tag, "_memWe"}, memWe, 0);
        check({tag, "_memAddr"}, memAddr, 0);
        check({tag, "_memWdata"}, memWdata, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_regWriteW"}, regWriteW, 0);
        check({tag, "_WA3W"}, WA3W, 0);
        check({tag, "_PCSrcW"}, PCSrcW, 0);
        check({tag, "_validW"}, validW, 0);
        check({tag, "_memErr"}, memErr, 0);
    endtask

    // Waits out any stall (feeding junk that must be ignored), then presents one instruction.
    task automatic issue(input logic store, input logic load, input logic rw,
                         input logic [3:0] wa, input logic pc, input logic [23:0] alu,
                         input logic [23:0] data, input int unsigned d);
        int   guard;
        exp_t e;
        guard = 0;
        while (stallE) begin
            validE    = 1'b1;
            regWriteE = 1'($urandom);
            memToRegE = 1'($urandom);
            memWriteE = 1'($urandom);
            PCSrcE    = 1'($urandom);
            WA3E      = 4'($urandom);
            aluResE   = 24'($urandom);
            dataE     = 24'($urandom);
            @(posedge clk);
            #1;
            guard++;
            if (guard > 300) begin
                $display("FAIL stall_bound: stallE still 1 after %0d cycles, required 0", guard);
                $fatal(1, "stall bound expired");
            end
        end
        validE    = 1'b1;
        regWriteE = rw;
        memToRegE = load;
        memWriteE = store;
        PCSrcE    = pc;
        WA3E      = wa;
        aluResE   = alu;
        dataE     = data;
        e.issue      = cyc + 1;
        e.pc_src     = pc;
        e.wa3        = wa;
        e.err        = 1'b0;
        e.chk_result = 1'b1;
        e.is_mem     = store || load;
        if (!e.is_mem) begin
            e.result    = alu;
            e.reg_write = rw;
            e.ret       = e.issue;
        end else begin
            req_q.push_back('{we: store, addr: alu[15:0], wdata: data});
            delay_q.push_back(d);
            if (TO_EN && d >= TO) begin
                e.ret        = e.issue + TO;
                e.err        = 1'b1;
                e.reg_write  = 1'b0;
                e.chk_result = 1'b0;
                e.result     = '0;
            end else begin
                e.ret = e.issue + d + 1;
                if (store) begin
                    e.result           = {8'h00, alu[15:0]};
                    e.reg_write        = 1'b0;
                    ref_mem[alu[15:0]] = data;
                end else begin
                    e.result    = ref_mem.exists(alu[15:0]) ? ref_mem[alu[15:0]]
                                                            : dflt(alu[15:0]);
                    e.reg_write = rw;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        validE = 1'b0;
    endtask

    // Memory responder: acks d cycles after first seeing a request, spurious acks when idle.
    bit          req_active = 1'b0;
    int unsigned wait_left = 0;
    initial begin
        memAck   = 1'b0;
        memRdata = '0;
        forever begin
            @(posedge clk);
            #1;
            memAck   = 1'b0;
            memRdata = 24'($urandom);
            if (rst || !memReq) begin
                req_active = 1'b0;
                memAck     = ($urandom_range(0, 7) == 0);
            end else begin
                if (!req_active) begin
                    req_active = 1'b1;
                    wait_left  = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
                end
                if (wait_left == 0) begin
                    memAck = 1'b1;
                    if (memWe) phys_mem[memAddr] = memWdata;
                    else memRdata = phys_mem.exists(memAddr) ? phys_mem[memAddr] : dflt(memAddr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // Monitor: checks retirements, stall window and the memory request on the falling edge.
    exp_t mon_e;
    req_t cur_req;
    bit   req_seen = 1'b0;
    bit   stall_exp;
    always @(negedge clk) begin
        if (!rst) begin
            stall_exp = 1'b0;
            foreach (exp_q[i]) begin
                if (exp_q[i].is_mem && cyc >= exp_q[i].issue && cyc < exp_q[i].ret)
                    stall_exp = 1'b1;
            end
            check("stallE", stallE, stall_exp);
            if (validW) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_retire: validW=1 result=%0h, required validW=0",
                             result);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("retire_cycle", cyc, mon_e.ret);
                    if (mon_e.chk_result) check("result", result, mon_e.result);
                    check("regWriteW", regWriteW, mon_e.reg_write);
                    check("WA3W", WA3W, mon_e.wa3);
                    check("PCSrcW", PCSrcW, mon_e.pc_src);
                    check("memErr", memErr, mon_e.err);
                end
            end else begin
                check("regWriteW_idle", regWriteW, 0);
                check("memErr_idle", memErr, 0);
                if (exp_q.size() > 0 && exp_q[0].ret < cyc) begin
                    check("missed_retire", cyc, exp_q[0].ret);
                    void'(exp_q.pop_front());
                end
            end
            if (memReq) begin
                if (!req_seen) begin
                    req_seen = 1'b1;
                    if (req_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_req: memReq=1 addr=%0h, required memReq=0",
                                 memAddr);
                        cur_req = '{we: memWe, addr: memAddr, wdata: memWdata};
                    end else begin
                        cur_req = req_q.pop_front();
                    end
                end
                check("memWe", memWe, cur_req.we);
                check("memAddr", memAddr, cur_req.addr);
                check("memWdata", memWdata, cur_req.wdata);
            end else begin
                req_seen = 1'b0;
            end
        end
    end

    initial begin
        int unsigned kind, gap;
        logic [15:0] a;
        rst       = 1'b1;
        validE    = 1'b0;
        regWriteE = 1'b0;
        memToRegE = 1'b0;
        memWriteE = 1'b0;
        PCSrcE    = 1'b0;
        WA3E      = '0;
        aluResE   = '0;
        dataE     = '0;
        ref_mem[16'h0040]  = 24'hABCDEF;
        phys_mem[16'h0040] = 24'hABCDEF;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        issue(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 24'h001234, 24'h0, 0);
        issue(1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 24'h5A0040, 24'h111111, 3);
        issue(1'b1, 1'b0, 1'b1, 4'd9, 1'b0, 24'h000010, 24'h000055, 1);
        issue(1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 24'hFF0010, 24'h0, 0);

        // Reset sampled in the second BUSY cycle of a load that never completes.
        issue(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 24'h000020, 24'h0, 99);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midbusy_rst");
        rst = 1'b0;
        exp_q.delete();
        req_q.delete();
        delay_q.delete();
        issue(1'b0, 1'b0, 1'b1, 4'd12, 1'b1, 24'hC0FFEE, 24'h0, 0);

        // Long wait: completes after 41 BUSY cycles, or times out in the timeout build.
        issue(1'b0, 1'b1, 1'b1, 4'd6, 1'b0, 24'h000008, 24'h0, 40);
        issue(1'b1, 1'b0, 1'b0, 4'd1, 1'b1, 24'h000009, 24'h00ABCD, 8);

        for (int n = 0; n < 300; n++) begin
            gap = $urandom_range(0, 3);
            if (gap > 1) repeat (gap - 1) begin
                @(posedge clk);
                #1;
            end
            kind = $urandom_range(0, 4);
            a    = 16'($urandom_range(0, 31));
            issue(kind == 3 || kind == 4, kind == 2 || kind == 4, 1'($urandom), 4'($urandom),
                  1'($urandom), {8'($urandom), a}, 24'($urandom), $urandom_range(0, 6));
        end

        begin
            int guard = 0;
            while (exp_q.size() != 0 && guard < 200) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
